// File: rtl/kf_tone_pkg.sv
// -----------------------------------------------------------------------------
// kf_tone_pkg
// Shared constants and helpers for the multi-channel PSG tone generator bank.
//   LEVEL_WIDTH : width of one channel's output level
//   ATT_WIDTH   : width of the attenuation register
//   ATT_TABLE   : attenuation-to-level map, 2 dB steps (index 0 loudest, 15 silent)
//   att_to_level: looks an attenuation code up in ATT_TABLE
// -----------------------------------------------------------------------------
package kf_tone_pkg;

   localparam int LEVEL_WIDTH = 6;
   localparam int ATT_WIDTH   = 4;

   // Packed so that ATT_TABLE[0] is the rightmost entry of the concatenation.
   localparam logic [15:0][LEVEL_WIDTH-1:0] ATT_TABLE = {
      6'd0,  6'd2,  6'd3,  6'd4,  6'd5,  6'd6,  6'd8,  6'd10,
      6'd13, 6'd16, 6'd20, 6'd25, 6'd32, 6'd40, 6'd50, 6'd63
   };

   function automatic logic [LEVEL_WIDTH-1:0] att_to_level(input logic [ATT_WIDTH-1:0] att);
      return ATT_TABLE[att];
   endfunction

endpackage

// File: rtl/kf_tone_channel.sv
// -----------------------------------------------------------------------------
// kf_tone_channel
// One square-wave tone channel: frequency and attenuation registers, a
// down-counting period divider, the digital output flop, a one-clock cycle
// pulse and the attenuation level lookup.
// Ports:
//   clock, reset            : clock and synchronous active-high reset
//   clock_enable            : divider tick qualifier shared by all channels
//   channel_enable          : 0 freezes the divider and silences the level
//   write_frequency_h/_l    : load upper / lower 6 frequency bits (h wins)
//   write_attenuation       : load the attenuation code from data_bus[7:4]
//   data_bus                : 8-bit write data
//   cycle_out               : registered one-clock pulse on every toggle
//   level_out               : combinational level from registered state
// -----------------------------------------------------------------------------
module kf_tone_channel
   import kf_tone_pkg::*;
#(
   parameter int FREQ_WIDTH         = 10,
   parameter int RETRIGGER_ON_WRITE = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clock_enable,
   input  logic                   channel_enable,
   input  logic                   write_frequency_h,
   input  logic                   write_frequency_l,
   input  logic                   write_attenuation,
   input  logic [7:0]             data_bus,
   output logic                   cycle_out,
   output logic [LEVEL_WIDTH-1:0] level_out
);

   // The upper frequency field is left-aligned on the bus.
   localparam int BUS_LSB = 14 - FREQ_WIDTH;

   logic [FREQ_WIDTH-1:0] freq_q, freq_d;
   logic [ATT_WIDTH-1:0]  att_q, att_d;
   logic [FREQ_WIDTH-1:0] count_q, count_d;
   logic                  digital_q, digital_d;
   logic                  cycle_q, cycle_d;

   // A zero frequency behaves like one: the divider still toggles every tick.
   function automatic logic [FREQ_WIDTH-1:0] reload_value(input logic [FREQ_WIDTH-1:0] f);
      logic [FREQ_WIDTH-1:0] r;
      if (f == '0) begin
         r = '0;
      end else begin
         r = f - FREQ_WIDTH'(1);
      end
      return r;
   endfunction

   // Register write decode; the high-half write takes precedence.
   always_comb begin
      freq_d = freq_q;
      att_d  = att_q;
      if (write_frequency_h) begin
         freq_d[FREQ_WIDTH-1:6] = data_bus[7:BUS_LSB];
      end else if (write_frequency_l) begin
         freq_d[5:0] = data_bus[7:2];
      end else begin
         freq_d = freq_q;
      end
      if (write_attenuation) begin
         att_d = data_bus[7:4];
      end else begin
         att_d = att_q;
      end
   end

   // Divider next state. A normal reload always uses the pre-write period
   // (freq_q); a retrigger uses the freshly written period (freq_d) and
   // overrides any reload happening on the same edge.
   always_comb begin
      count_d   = count_q;
      digital_d = digital_q;
      cycle_d   = 1'b0;
      if ((RETRIGGER_ON_WRITE != 0) && write_frequency_h) begin
         count_d   = reload_value(freq_d);
         digital_d = 1'b0;
      end else if (clock_enable && channel_enable) begin
         if (count_q != '0) begin
            count_d = count_q - FREQ_WIDTH'(1);
         end else begin
            count_d   = reload_value(freq_q);
            digital_d = ~digital_q;
            cycle_d   = 1'b1;
         end
      end else begin
         count_d   = count_q;
         digital_d = digital_q;
      end
   end

   // Channel state registers; count restarts at 1 so the first toggle is
   // two ticks after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         freq_q    <= '0;
         att_q     <= '0;
         count_q   <= FREQ_WIDTH'(1);
         digital_q <= 1'b0;
         cycle_q   <= 1'b0;
      end else begin
         freq_q    <= freq_d;
         att_q     <= att_d;
         count_q   <= count_d;
         digital_q <= digital_d;
         cycle_q   <= cycle_d;
      end
   end

   assign cycle_out = cycle_q;
   // A muted channel keeps its digital state but contributes no level.
   assign level_out = (digital_q && channel_enable) ? att_to_level(att_q) : '0;

endmodule

// File: rtl/kf_tone_generator_bank.sv
// -----------------------------------------------------------------------------
// kf_tone_generator_bank
// CHANNELS independent PSG tone channels written through one shared 8-bit
// bus, with a registered sum of all channel levels for the mixer/DAC stage.
// Ports:
//   clock, reset         : clock and synchronous active-high reset
//   clock_enable         : divider tick qualifier (writes ignore it)
//   internal_data_bus    : 8-bit write data
//   channel_select       : target channel; values >= CHANNELS drop the write
//   write_frequency_h/_l : frequency upper / lower-6-bit write strobes
//   write_attenuation    : attenuation write strobe
//   channel_enable       : per-channel enable; 0 mutes and freezes a channel
//   cycle_out            : per-channel one-clock toggle pulse
//   analog_out           : per-channel 6-bit level, channel n at [6n+5:6n]
//   mix_out              : registered sum of all analog_out levels
// -----------------------------------------------------------------------------
module kf_tone_generator_bank
   import kf_tone_pkg::*;
#(
   parameter int CHANNELS           = 3,
   parameter int FREQ_WIDTH         = 10,
   parameter int RETRIGGER_ON_WRITE = 0,
   parameter int CH_SEL_WIDTH       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   parameter int MIX_WIDTH          = 6 + $clog2(CHANNELS + 1)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            clock_enable,
   input  logic [7:0]                      internal_data_bus,
   input  logic [CH_SEL_WIDTH-1:0]         channel_select,
   input  logic                            write_frequency_h,
   input  logic                            write_frequency_l,
   input  logic                            write_attenuation,
   input  logic [CHANNELS-1:0]             channel_enable,
   output logic [CHANNELS-1:0]             cycle_out,
   output logic [CHANNELS*LEVEL_WIDTH-1:0] analog_out,
   output logic [MIX_WIDTH-1:0]            mix_out
);

   logic                            sel_valid_s;
   logic [CHANNELS-1:0]             wr_h_s;
   logic [CHANNELS-1:0]             wr_l_s;
   logic [CHANNELS-1:0]             wr_att_s;
   logic [CHANNELS*LEVEL_WIDTH-1:0] level_s;
   logic [MIX_WIDTH-1:0]            mix_d;
   logic [MIX_WIDTH-1:0]            mix_q;

   // Selects past the last channel are possible when CHANNELS is not a power of two.
   assign sel_valid_s = (32'(channel_select) < 32'(CHANNELS));

   // Route each write strobe to the addressed channel only.
   always_comb begin
      wr_h_s   = '0;
      wr_l_s   = '0;
      wr_att_s = '0;
      for (int n = 0; n < CHANNELS; n++) begin
         if (sel_valid_s && (32'(channel_select) == 32'(n))) begin
            wr_h_s[n]   = write_frequency_h;
            wr_l_s[n]   = write_frequency_l;
            wr_att_s[n] = write_attenuation;
         end else begin
            wr_h_s[n]   = 1'b0;
            wr_l_s[n]   = 1'b0;
            wr_att_s[n] = 1'b0;
         end
      end
   end

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      kf_tone_channel #(
         .FREQ_WIDTH         (FREQ_WIDTH),
         .RETRIGGER_ON_WRITE (RETRIGGER_ON_WRITE)
      ) u_channel (
         .clock             (clock),
         .reset             (reset),
         .clock_enable      (clock_enable),
         .channel_enable    (channel_enable[n]),
         .write_frequency_h (wr_h_s[n]),
         .write_frequency_l (wr_l_s[n]),
         .write_attenuation (wr_att_s[n]),
         .data_bus          (internal_data_bus),
         .cycle_out         (cycle_out[n]),
         .level_out         (level_s[n*LEVEL_WIDTH +: LEVEL_WIDTH])
      );
   end

   // Sum of all levels; MIX_WIDTH holds CHANNELS*63 without overflow.
   always_comb begin
      mix_d = '0;
      for (int n = 0; n < CHANNELS; n++) begin
         mix_d = mix_d + MIX_WIDTH'(level_s[n*LEVEL_WIDTH +: LEVEL_WIDTH]);
      end
   end

   // Mix register, one clock behind analog_out.
   always_ff @(posedge clock) begin
      if (reset) begin
         mix_q <= '0;
      end else begin
         mix_q <= mix_d;
      end
   end

   assign analog_out = level_s;
   assign mix_out    = mix_q;

endmodule
